// File: rtl/dcount_pacer_if.sv
// Control/status bundle between a sequencer and dcount_pacer.
// The auto_reload input exists only when DCOUNT_PACER_AUTORELOAD_EN is defined.
interface dcount_pacer_if #(
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned BURST_W    = 16
) ();

  logic                  i_start;
  logic                  i_stop;
  logic [PRESCALE_W-1:0] i_prescale;
  logic [BURST_W-1:0]    i_burst_len;
`ifdef DCOUNT_PACER_AUTORELOAD_EN
  logic                  i_auto_reload;
`endif
  logic                  o_cnt_clr;
  logic                  o_d_en;
  logic                  o_busy;
  logic                  o_done;
  logic [BURST_W-1:0]    o_pulses_left;

  modport master (
`ifdef DCOUNT_PACER_AUTORELOAD_EN
    output i_auto_reload,
`endif
    output i_start,
    output i_stop,
    output i_prescale,
    output i_burst_len,
    input  o_cnt_clr,
    input  o_d_en,
    input  o_busy,
    input  o_done,
    input  o_pulses_left
  );

  modport slave (
`ifdef DCOUNT_PACER_AUTORELOAD_EN
    input  i_auto_reload,
`endif
    input  i_start,
    input  i_stop,
    input  i_prescale,
    input  i_burst_len,
    output o_cnt_clr,
    output o_d_en,
    output o_busy,
    output o_done,
    output o_pulses_left
  );

endinterface

// File: rtl/dcount_pacer.sv
// Paces a 16-bit down-counter: clear pulse per run, then d_en pulses every prescale+1 cycles.
// Define DCOUNT_PACER_AUTORELOAD_EN to let DONE restart the run when auto_reload is high.
module dcount_pacer #(
  parameter int unsigned PRESCALE_W = 16,
  parameter int unsigned BURST_W    = 16
) (
  input  logic           i_clock,
  input  logic           i_rst_n,
  dcount_pacer_if.slave  bus
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } state_e;

  state_e                r_state;
  logic [PRESCALE_W-1:0] r_prescaler;
  logic [PRESCALE_W-1:0] r_cfg_p;
  logic [BURST_W-1:0]    r_cfg_b;
  logic [BURST_W-1:0]    r_pulses_left;

  state_e                w_state_d;
  logic [PRESCALE_W-1:0] w_prescaler_d;
  logic [PRESCALE_W-1:0] w_cfg_p_d;
  logic [BURST_W-1:0]    w_cfg_b_d;
  logic [BURST_W-1:0]    w_pulses_left_d;

  logic                  w_d_en;
  logic                  w_burst_mode;
  logic                  w_last_pulse;
  logic                  w_reload;

  assign w_d_en       = (r_state == StRun) && (r_prescaler == '0);
  assign w_burst_mode = (r_cfg_b != '0);
  assign w_last_pulse = w_d_en && w_burst_mode && (r_pulses_left == BURST_W'(1));

`ifdef DCOUNT_PACER_AUTORELOAD_EN
  assign w_reload = bus.i_auto_reload && !bus.i_stop;
`else
  assign w_reload = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_prescaler   <= '0;
      r_cfg_p       <= '0;
      r_cfg_b       <= '0;
      r_pulses_left <= '0;
    end else begin
      r_state       <= w_state_d;
      r_prescaler   <= w_prescaler_d;
      r_cfg_p       <= w_cfg_p_d;
      r_cfg_b       <= w_cfg_b_d;
      r_pulses_left <= w_pulses_left_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_prescaler_d   = r_prescaler;
    w_cfg_p_d       = r_cfg_p;
    w_cfg_b_d       = r_cfg_b;
    w_pulses_left_d = r_pulses_left;

    unique case (r_state)
      StIdle: begin
        // stop wins over a simultaneous start
        if (bus.i_start && !bus.i_stop) begin
          w_state_d       = StClear;
          w_cfg_p_d       = bus.i_prescale;
          w_cfg_b_d       = bus.i_burst_len;
          w_pulses_left_d = bus.i_burst_len;
        end
      end

      StClear: begin
        if (bus.i_stop) begin
          w_state_d = StIdle;
        end else begin
          w_state_d     = StRun;
          w_prescaler_d = r_cfg_p;
        end
      end

      StRun: begin
        if (w_d_en) begin
          w_prescaler_d = r_cfg_p;
          if (w_burst_mode && (r_pulses_left != '0)) begin
            w_pulses_left_d = r_pulses_left - BURST_W'(1);
          end
        end else begin
          w_prescaler_d = r_prescaler - PRESCALE_W'(1);
        end

        // A pulse visible this cycle is still counted even when stop aborts the run.
        if (bus.i_stop) begin
          w_state_d = StIdle;
        end else if (w_last_pulse) begin
          w_state_d = StDone;
        end
      end

      StDone: begin
        if (w_reload) begin
          w_state_d       = StClear;
          w_cfg_p_d       = bus.i_prescale;
          w_cfg_b_d       = bus.i_burst_len;
          w_pulses_left_d = bus.i_burst_len;
        end else begin
          w_state_d = StIdle;
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // Moore outputs: all decoded from registered state, so reset clears them at once.
  assign bus.o_cnt_clr     = (r_state == StClear);
  assign bus.o_d_en        = w_d_en;
  assign bus.o_busy        = (r_state != StIdle);
  assign bus.o_done        = (r_state == StDone);
  assign bus.o_pulses_left = r_pulses_left;

endmodule

// File: tb/tb_dcount_pacer.sv
// Scoreboarded bench for dcount_pacer: per-cycle expected output vectors are queued
// from cycle-index formulas and popped at each falling edge.
module tb_dcount_pacer;

  localparam int unsigned PW = 16;
  localparam int unsigned BW = 16;
  localparam int unsigned VW = BW + 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dcount_pacer_if #(.PRESCALE_W(PW), .BURST_W(BW)) bus ();

  dcount_pacer #(.PRESCALE_W(PW), .BURST_W(BW)) dut (
    .i_clock (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [VW-1:0] sb[$];
  logic [VW-1:0] e_vec;
  logic [VW-1:0] obs;

  assign obs = {bus.o_cnt_clr, bus.o_d_en, bus.o_busy, bus.o_done, bus.o_pulses_left};

  // Expected {cnt_clr, d_en, busy, done, pulses_left} in cycle c of a run started at edge 0.
  // b != 0: burst of b pulses; b == 0: continuous, stop high in cycle stop_c.
  function automatic logic [VW-1:0] run_vec(int c, int p, int b, int stop_c);
    int period = p + 1;
    int last   = (b != 0) ? b * period : stop_c;
    int pulses;
    logic clr, den, bsy, dn;
    int pl;
    clr = (c == 0);
    den = (c >= period) && (((c - period) % period) == 0) && (c <= last);
    bsy = (b != 0) ? (c <= last + 1) : (c <= stop_c);
    dn  = (b != 0) && (c == last + 1);
    pulses = (c <= period) ? 0 : ((c - 1 - period) / period) + 1;
    if (pulses > b) pulses = b;
    pl = (b != 0) ? b - pulses : 0;
    return {clr, den, bsy, dn, BW'(pl)};
  endfunction

  // Presents config with start so that it is sampled at the next rising edge (edge 0).
  task automatic start_run(input int p, input int b);
    @(negedge clk);
    bus.i_prescale  = PW'(p);
    bus.i_burst_len = BW'(b);
    bus.i_start     = 1'b1;
    @(posedge clk);
    #1 bus.i_start  = 1'b0;
  endtask

  task automatic test_reset();
    bus.i_start     = 1'b0;
    bus.i_stop      = 1'b0;
    bus.i_prescale  = '0;
    bus.i_burst_len = '0;
`ifdef DCOUNT_PACER_AUTORELOAD_EN
    bus.i_auto_reload = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      sb.push_back('0);
      @(negedge clk);
      e_vec = sb.pop_front();
      n_vec++;
      if (obs !== e_vec) begin
        n_miss++;
        $display("FAIL reset c%0d: got %h want %h", c, obs, e_vec);
      end
      if (c == 2) rst_n = 1'b1;
    end
  endtask

  task automatic test_burst();
    start_run(3, 4);
    for (int c = 0; c < 20; c++) sb.push_back(run_vec(c, 3, 4, 0));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e_vec = sb.pop_front();
      n_vec++;
      if (obs !== e_vec) begin
        n_miss++;
        $display("FAIL burst c%0d: got %h want %h", c, obs, e_vec);
      end
    end
  endtask

  task automatic test_continuous(input int p, input int stop_c);
    start_run(p, 0);
    for (int c = 0; c < stop_c + 4; c++) sb.push_back(run_vec(c, p, 0, stop_c));
    for (int c = 0; c < stop_c + 4; c++) begin
      @(negedge clk);
      e_vec = sb.pop_front();
      n_vec++;
      if (obs !== e_vec) begin
        n_miss++;
        $display("FAIL continuous p%0d c%0d: got %h want %h", p, c, obs, e_vec);
      end
      bus.i_stop = (c == stop_c);
    end
    bus.i_stop = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    start_run(3, 4);
    for (int c = 0; c < 20; c++) sb.push_back(run_vec(c, 3, 4, 0));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e_vec = sb.pop_front();
      n_vec++;
      if (obs !== e_vec) begin
        n_miss++;
        $display("FAIL start_busy c%0d: got %h want %h", c, obs, e_vec);
      end
      // Restart attempt with different config mid-run; none of it may be taken.
      if (c == 3) begin
        bus.i_start     = 1'b1;
        bus.i_prescale  = PW'(0);
        bus.i_burst_len = BW'(9);
      end
      if (c == 4) bus.i_start = 1'b0;
    end
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b1;
    for (int c = 0; c < 4; c++) sb.push_back('0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e_vec = sb.pop_front();
      n_vec++;
      if (obs !== e_vec) begin
        n_miss++;
        $display("FAIL start_stop_idle c%0d: got %h want %h", c, obs, e_vec);
      end
      if (c == 1) begin
        bus.i_start = 1'b0;
        bus.i_stop  = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    start_run(3, 4);
    for (int c = 0; c < 7; c++) sb.push_back(run_vec(c, 3, 4, 0));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      e_vec = sb.pop_front();
      n_vec++;
      if (obs !== e_vec) begin
        n_miss++;
        $display("FAIL pre_reset c%0d: got %h want %h", c, obs, e_vec);
      end
    end
    // Assert reset mid-cycle; outputs must fall without a clock edge.
    #1 rst_n = 1'b0;
    sb.push_back('0);
    #1;
    e_vec = sb.pop_front();
    n_vec++;
    if (obs !== e_vec) begin
      n_miss++;
      $display("FAIL async_reset_drop: got %h want %h", obs, e_vec);
    end
    sb.push_back('0);
    @(negedge clk);
    e_vec = sb.pop_front();
    n_vec++;
    if (obs !== e_vec) begin
      n_miss++;
      $display("FAIL async_reset_hold: got %h want %h", obs, e_vec);
    end
    rst_n = 1'b1;
    start_run(3, 4);
    for (int c = 0; c < 20; c++) sb.push_back(run_vec(c, 3, 4, 0));
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e_vec = sb.pop_front();
      n_vec++;
      if (obs !== e_vec) begin
        n_miss++;
        $display("FAIL post_reset c%0d: got %h want %h", c, obs, e_vec);
      end
    end
  endtask

`ifdef DCOUNT_PACER_AUTORELOAD_EN
  task automatic test_autoreload();
    logic [VW-1:0] v;
    int m;
    bus.i_auto_reload = 1'b1;
    start_run(0, 2);
    for (int c = 0; c < 15; c++) begin
      m = c % 4;
      if (c < 12) begin
        v = {(m == 0), (m == 1) || (m == 2), 1'b1, (m == 3),
             BW'((m == 0 || m == 1) ? 2 : (m == 2) ? 1 : 0)};
      end else begin
        v = '0;
      end
      sb.push_back(v);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      e_vec = sb.pop_front();
      n_vec++;
      if (obs !== e_vec) begin
        n_miss++;
        $display("FAIL autoreload c%0d: got %h want %h", c, obs, e_vec);
      end
      if (c == 9) bus.i_auto_reload = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_burst();
    test_continuous(0, 9);
    test_continuous(1, 5);
    test_ignored_inputs();
    test_async_reset();
`ifdef DCOUNT_PACER_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dcount_pacer.md
Name: dcount_pacer

Overview:
- Upstream control stage for the 16-bit down-counter. Generates its decrement-enable (d_en) as one-cycle pulses at a programmable rate.
- Issues a one-cycle clear pulse to the counter at the start of every run.
- Runs either a fixed-length burst of N enables or continuously until stopped.
- Gives software and sequencing logic a deterministic way to pace the counter.

Parameters:
- PRESCALE_W, 16, width of prescale input and internal prescaler.
- BURST_W, 16, width of burst_len input and pulses_left output.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  run request; sampled only in IDLE.
- stop  in  1  abort request; sampled in CLEAR and RUN.
- prescale  in  PRESCALE_W  enable period minus 1 (period = prescale+1 cycles).
- burst_len  in  BURST_W  number of d_en pulses per run; 0 = continuous.
- cnt_clr  out  1  one-cycle clear pulse to the counter's synchronous reset.
- d_en  out  1  one-cycle decrement enable to the counter.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when a burst completes (not on stop).
- pulses_left  out  BURST_W  remaining enables in the current burst.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; prescaler, latched config and pulses_left all 0.
  - All outputs go 0 immediately, without waiting for a clock edge.
  - Release is synchronous to the next edge.
- Outputs are Moore decodes of registered state; no combinational path from inputs to outputs.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE:
  - start=1 and stop=0 at an edge -> CLEAR. On that same edge, latch prescale into cfg_p, burst_len into cfg_b and pulses_left.
  - start=1 and stop=1 together -> stay in IDLE; stop wins.
- CLEAR:
  - cnt_clr=1 for exactly this one cycle.
  - Next edge -> RUN, loading prescaler=cfg_p.
  - stop=1 at that edge -> IDLE.
- RUN:
  - d_en=1 in any cycle where prescaler==0.
  - Each edge: if prescaler==0, reload prescaler=cfg_p; otherwise decrement it.
  - With prescale=0, d_en is high every RUN cycle.
  - Edge with d_en=1 and cfg_b!=0: pulses_left decrements. If pulses_left was 1 -> DONE.
  - stop=1 at an edge -> IDLE; takes priority over the DONE transition.
  - A d_en already visible in the cycle stop is high still counts, and pulses_left still updates on that edge.
  - cfg_b==0: pulses_left holds 0 and the run continues until stop.
- DONE: done=1 for one cycle; next edge -> IDLE.
- Inputs are ignored outside their sampling states: start outside IDLE, prescale/burst_len outside the IDLE->CLEAR edge.
- No wrap-around: the prescaler reloads at 0 and never underflows; pulses_left never decrements below 0.
- Latency: start sampled at edge 0 gives:
  - cnt_clr in cycle 0 (the cycle after edge 0);
  - first d_en in cycle 1+prescale;
  - later d_en pulses every prescale+1 cycles.

Optional Feature:
- Macro: DCOUNT_PACER_AUTORELOAD_EN.
- Defined:
  - Extra input port auto_reload (1 bit).
  - In DONE with auto_reload=1, next state is CLEAR instead of IDLE. Config is re-latched from the current prescale/burst_len, done still pulses, and busy stays high.
  - stop in DONE -> IDLE.
- Undefined: auto_reload port absent; DONE always -> IDLE.

Test Plan:
- prescale=3, burst_len=4, start pulsed at edge 0:
  - cnt_clr high cycle 0 only;
  - d_en high cycles 4, 8, 12, 16 only;
  - pulses_left 4->3->2->1->0 after each pulse;
  - done high cycle 17; busy high cycles 0-17, low from 18.
- prescale=0, burst_len=0, start at edge 0, stop high in cycle 9: d_en high every cycle 1-9; state IDLE from cycle 10; done never asserts.
- prescale=1, burst_len=0, start at edge 0 (d_en cycles 2, 4, ...), stop high in cycle 5: no d_en in cycle 6 or later; busy low from cycle 6.
- Start while busy (cycle 3 of a run) and start+stop together in IDLE: both ignored; pulse timing unchanged; IDLE holds.
- rst driven low mid-burst between clock edges: d_en, cnt_clr, busy, done and pulses_left drop to 0 before the next edge. After release, start reproduces the first scenario exactly.
- With DCOUNT_PACER_AUTORELOAD_EN, auto_reload=1, prescale=0, burst_len=2:
  - repeating pattern cnt_clr, d_en, d_en, done, cnt_clr, and so on;
  - busy never drops;
  - dropping auto_reload returns to IDLE after the next done.
